io_uart: RTL and testbench

//  Memory-mapped UART peripheral on the core's io bus (io_address/io_write_en/io_read_en).

---
 rtl/io_uart.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_io_uart.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart.sv
`default_nettype none
// ----------------------------------------------------------------------------
// io_uart: io-bus UART with a byte TX shifter and a mid-bit sampling RX + FIFO
// Revision: 1.0
// ----------------------------------------------------------------------------
module io_uart #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h18,
  parameter int unsigned BAUD_DIVIDE   = 50000000 / 115200,
  parameter int unsigned RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_address,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIVIDE);
  localparam int unsigned PTR_W = $clog2(RX_FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIVIDE - 1);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(BAUD_DIVIDE / 2);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(RX_FIFO_DEPTH);

  localparam logic [31:0] STATUS_ADDR = BASE_ADDRESS;
  localparam logic [31:0] TXDATA_ADDR = BASE_ADDRESS + 32'd4;
  localparam logic [31:0] RXDATA_ADDR = BASE_ADDRESS + 32'd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_out_q, tx_out_d;

  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic             rx_prev_q, rx_prev_d;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;

  logic [7:0]       fifo_mem_q [RX_FIFO_DEPTH];
  logic [7:0]       fifo_mem_d [RX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic [31:0]      rd_data_q, rd_data_d;

  logic wr_tx, rd_status, rd_rx;
  logic tx_ready, rx_avail, rx_fall;
  logic push, pop, push_ok, overrun_evt, frame_evt;
  logic unused_wdata;

  assign unused_wdata = ^io_write_data[31:8];

  assign wr_tx     = io_write_en && (io_address == TXDATA_ADDR);
  assign rd_status = io_read_en && (io_address == STATUS_ADDR);
  assign rd_rx     = io_read_en && (io_address == RXDATA_ADDR);
  assign tx_ready  = (tx_state_q == ST_IDLE);
  assign rx_avail  = (count_q != '0);
  assign rx_fall   = rx_prev_q && !rx_sync_q;

  // TX: each non-idle state holds for BAUD_DIVIDE cycles via tx_cnt
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    case (tx_state_q)
      ST_IDLE: begin
        tx_out_d = 1'b1;
        if (wr_tx) begin
          tx_state_d = ST_START;
          tx_cnt_d   = BIT_LAST;
          tx_shift_d = io_write_data[7:0];
          tx_out_d   = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = 3'd0;
          tx_out_d   = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_out_d   = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_out_d   = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      default: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
    endcase
  end

  // RX: counter preloaded with half a bit so every sample lands mid-bit
  always_comb begin
    rx_meta_d  = uart_rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    push       = 1'b0;
    frame_evt  = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_d = ST_START;
          rx_cnt_d   = HALF_BIT;
        end
      end
      ST_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_sync_q) begin
            rx_state_d = ST_IDLE;
          end else begin
            rx_state_d = ST_DATA;
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      default: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = ST_IDLE;
          push       = rx_sync_q;
          frame_evt  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
    endcase
  end

  // A simultaneous pop frees the head slot, so a push into a full FIFO still fits
  assign pop         = rd_rx && rx_avail;
  assign overrun_evt = push && !pop && (count_q == FIFO_FULL);
  assign push_ok     = push && !overrun_evt;

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (rd_status) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (overrun_evt) begin
      overrun_d = 1'b1;
    end
    if (frame_evt) begin
      frame_err_d = 1'b1;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (io_read_en) begin
      rd_data_d = 32'd0;
      if (rd_status) begin
        rd_data_d = {28'd0, frame_err_q, overrun_q, rx_avail, tx_ready};
      end else if (rd_rx && rx_avail) begin
        rd_data_d = {24'd0, fifo_mem_q[rd_ptr_q]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'd0;
      tx_out_q    <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      fifo_mem_q  <= '{default: 8'd0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rd_data_q   <= 32'd0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_out_q    <= tx_out_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign io_read_data = rd_data_q;
  assign uart_tx      = tx_out_q;

endmodule
`default_nettype wire

// File: tb/tb_io_uart.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_io_uart: directed register-table and serial-frame checks for io_uart
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_io_uart;

  localparam logic [31:0] A_STATUS = 32'h18;
  localparam logic [31:0] A_TX     = 32'h1C;
  localparam logic [31:0] A_RX     = 32'h20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] io_address = 32'd0;
  logic        io_write_en = 1'b0;
  logic        io_read_en = 1'b0;
  logic [31:0] io_write_data = 32'd0;
  logic [31:0] io_read_data;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_tx;
  } vec_t;

  vec_t vecs [13];

  io_uart #(
    .BASE_ADDRESS (32'h18),
    .BAUD_DIVIDE  (8),
    .RX_FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_address   (io_address),
    .io_write_en  (io_write_en),
    .io_read_en   (io_read_en),
    .io_write_data(io_write_data),
    .io_read_data (io_read_data),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge
  task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
    io_address    = addr;
    io_write_data = data;
    io_write_en   = 1'b1;
    @(negedge clk);
    io_write_en   = 1'b0;
  endtask

  task automatic io_read(input logic [31:0] addr, output logic [31:0] data);
    io_address = addr;
    io_read_en = 1'b1;
    @(negedge clk);
    io_read_en = 1'b0;
    data       = io_read_data;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (8) @(negedge clk);
    end
    uart_rx = stop;
    repeat (8) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Called right after a TX_DATA write: samples each bit mid-pitch, optionally
  // injects a second write at cycle wr_at, and reads STATUS at cycles 40/79/80.
  task automatic tx_run(input int wr_at, input logic [7:0] wr_data,
                        output logic [9:0] bits, output logic [31:0] st_mid,
                        output logic [31:0] st_79, output logic [31:0] st_80);
    int rd_j;
    rd_j = -1;
    bits = '0;
    st_mid = 32'hdead; st_79 = 32'hdead; st_80 = 32'hdead;
    for (int j = 0; j <= 81; j++) begin
      if (rd_j >= 0) begin
        io_read_en = 1'b0;
        if (rd_j == 40) st_mid = io_read_data;
        if (rd_j == 79) st_79 = io_read_data;
        if (rd_j == 80) st_80 = io_read_data;
        rd_j = -1;
      end
      if (j == wr_at + 1) io_write_en = 1'b0;
      if ((j % 8 == 4) && (j < 80)) bits[j / 8] = uart_tx;
      if (j == wr_at) begin
        io_address    = A_TX;
        io_write_data = {24'd0, wr_data};
        io_write_en   = 1'b1;
      end
      if (j == 40 || j == 79 || j == 80) begin
        io_address = A_STATUS;
        io_read_en = 1'b1;
        rd_j       = j;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  bits;
    logic [31:0] s_mid, s79, s80;
    int          zeros;

    //            wr    rd    addr          wdata     exp_rd  exp_tx
    vecs[0]  = '{1'b0, 1'b1, A_STATUS,     32'h0,    32'h1,  1'b1};
    vecs[1]  = '{1'b0, 1'b0, A_STATUS,     32'h0,    32'h1,  1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h14,       32'h0,    32'h0,  1'b1};
    vecs[3]  = '{1'b0, 1'b1, A_STATUS,     32'h0,    32'h1,  1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h19,       32'h0,    32'h0,  1'b1};
    vecs[5]  = '{1'b0, 1'b1, A_STATUS,     32'h0,    32'h1,  1'b1};
    vecs[6]  = '{1'b0, 1'b1, A_TX,         32'h0,    32'h0,  1'b1};
    vecs[7]  = '{1'b0, 1'b1, A_STATUS,     32'h0,    32'h1,  1'b1};
    vecs[8]  = '{1'b0, 1'b1, A_RX,         32'h0,    32'h0,  1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h1D,       32'h55,   32'h0,  1'b1};
    vecs[10] = '{1'b1, 1'b0, A_STATUS,     32'hFF,   32'h0,  1'b1};
    vecs[11] = '{1'b0, 1'b1, A_STATUS,     32'h0,    32'h1,  1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h118,      32'h0,    32'h0,  1'b1};

    repeat (3) @(negedge clk);
    chk("reset_read_data", io_read_data, 32'h0);
    chk("reset_uart_tx", {31'd0, uart_tx}, 32'h1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      io_address    = vecs[i].addr;
      io_write_data = vecs[i].wdata;
      io_write_en   = vecs[i].wr;
      io_read_en    = vecs[i].rd;
      @(negedge clk);
      io_write_en = 1'b0;
      io_read_en  = 1'b0;
      chk($sformatf("vec%0d_read_data", i), io_read_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_uart_tx", i), {31'd0, uart_tx}, {31'd0, vecs[i].exp_tx});
    end

    // TX frame 0x55 with tx_ready timing
    io_write(A_TX, 32'h55);
    tx_run(-10, 8'h00, bits, s_mid, s79, s80);
    chk("tx55_bits", {22'd0, bits}, {22'd0, 1'b1, 8'h55, 1'b0});
    chk("tx55_status_mid", s_mid, 32'h0);
    chk("tx55_status_at80", s79, 32'h0);
    chk("tx55_status_at81", s80, 32'h1);

    // Write while busy is dropped
    io_write(A_TX, 32'h41);
    tx_run(20, 8'h42, bits, s_mid, s79, s80);
    chk("tx41_bits", {22'd0, bits}, {22'd0, 1'b1, 8'h41, 1'b0});
    zeros = 0;
    for (int j = 0; j < 40; j++) begin
      if (uart_tx == 1'b0) zeros++;
      @(negedge clk);
    end
    chk("tx42_dropped_idle_zeros", zeros, 32'd0);

    // Single RX byte
    rx_send(8'hA3, 1'b1);
    io_read(A_STATUS, rd); chk("rxA3_status", rd, 32'h3);
    io_read(A_RX, rd);     chk("rxA3_data", rd, 32'hA3);
    io_read(A_STATUS, rd); chk("rxA3_status_after", rd, 32'h1);
    io_read(A_RX, rd);     chk("rxA3_empty_read", rd, 32'h0);

    // FIFO overrun
    for (int b = 1; b <= 5; b++) rx_send(8'(b), 1'b1);
    io_read(A_STATUS, rd); chk("ovr_status_set", rd, 32'h7);
    io_read(A_STATUS, rd); chk("ovr_status_clr", rd, 32'h3);
    for (int b = 1; b <= 4; b++) begin
      io_read(A_RX, rd);
      chk($sformatf("ovr_pop%0d", b), rd, 32'(b));
    end
    io_read(A_STATUS, rd); chk("ovr_status_empty", rd, 32'h1);
    io_read(A_RX, rd);     chk("ovr_empty_read", rd, 32'h0);

    // False start, then a framing error
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    io_read(A_STATUS, rd); chk("glitch_status", rd, 32'h1);
    rx_send(8'h7E, 1'b0);
    io_read(A_STATUS, rd); chk("ferr_status", rd, 32'h9);
    io_read(A_STATUS, rd); chk("ferr_status_clr", rd, 32'h1);
    io_read(A_RX, rd);     chk("ferr_no_data", rd, 32'h0);

    // Reset mid TX and mid RX
    io_write(A_TX, 32'h5A);
    uart_rx = 1'b0;
    repeat (30) @(negedge clk);
    chk("midframe_tx_low", {31'd0, uart_tx}, 32'h0);
    reset = 1'b1;
    #1;
    chk("reset_tx_immediate", {31'd0, uart_tx}, 32'h1);
    chk("reset_read_data_mid", io_read_data, 32'h0);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    io_read(A_STATUS, rd); chk("post_reset_status", rd, 32'h1);
    io_read(A_RX, rd);     chk("post_reset_empty", rd, 32'h0);
    rx_send(8'hC4, 1'b1);
    io_read(A_STATUS, rd); chk("post_reset_rx_status", rd, 32'h3);
    io_read(A_RX, rd);     chk("post_reset_rx_data", rd, 32'hC4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
